// File: rtl/rr_grant_scheduler.sv
// Round-robin grant scheduler: one owner at a time, held until release, drop or
// hold timeout, with a dead cycle between owners and a rotating priority pointer.
module rr_grant_scheduler #(
    parameter int N        = 8,
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N-1:0]     req,
    input  logic             rel,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld,
    output logic             timeout
);

    localparam int HC_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    logic [1:0]      state_reg;
    logic [IDX_W-1:0] ptr_reg;
    logic [HC_W-1:0] hold_cnt_reg;

    logic [IDX_W-1:0] win_idx_next;
    logic [N-1:0]     win_onehot_next;
    logic [IDX_W-1:0] ptr_next;
    logic             hit_limit;
    logic             early_exit;

    // Scan from the farthest offset down so the offset closest to ptr wins last.
    always_comb begin
        win_idx_next = '0;
        for (int k = N - 1; k >= 0; k--) begin
            int pos;
            pos = int'(ptr_reg) + k;
            if (pos >= N) pos = pos - N;
            if (req[pos]) win_idx_next = IDX_W'(pos);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_onehot
            assign win_onehot_next[gi] = (win_idx_next == IDX_W'(gi));
        end
    endgenerate

    assign ptr_next   = (win_idx_next == IDX_W'(N - 1)) ? '0 : win_idx_next + 1'b1;
    assign hit_limit  = (MAX_HOLD != 0) && (hold_cnt_reg == HC_W'(MAX_HOLD));
    assign early_exit = rel || !req[gnt_idx] || !en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            ptr_reg      <= '0;
            hold_cnt_reg <= '0;
            gnt          <= '0;
            gnt_idx      <= '0;
            gnt_vld      <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    timeout <= 1'b0;
                    if (en && |req) begin
                        state_reg    <= ST_GRANT;
                        gnt          <= win_onehot_next;
                        gnt_idx      <= win_idx_next;
                        gnt_vld      <= 1'b1;
                        hold_cnt_reg <= HC_W'(1);
                        ptr_reg      <= ptr_next;
                    end
                end
                ST_GRANT: begin
                    if (early_exit || hit_limit) begin
                        state_reg <= ST_RELEASE;
                        gnt       <= '0;
                        gnt_idx   <= '0;
                        gnt_vld   <= 1'b0;
                        // Flag only releases forced purely by the hold limit.
                        timeout   <= hit_limit && !early_exit;
                    end else if (hold_cnt_reg != '1) begin
                        hold_cnt_reg <= hold_cnt_reg + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    timeout   <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    gnt       <= '0;
                    gnt_idx   <= '0;
                    gnt_vld   <= 1'b0;
                    timeout   <= 1'b0;
                end
            endcase
        end
    end

endmodule
